// File: rtl/muldiv_if.sv
// Handshake/operand bundle between the EX stage and the iterative RV32M multiply/divide unit.
// The pipeline side drives the op request; the unit returns stall/busy/done/result.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, func3, rs1, rs2, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, func3, rs1, rs2, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with a final sign-fix cycle and single-cycle divide special cases.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic clk,
  input  logic rst,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};

  function automatic logic rs1_is_signed(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b110: rs1_is_signed = 1'b1;
      default:                                rs1_is_signed = 1'b0;
    endcase
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b100, 3'b110: rs2_is_signed = 1'b1;
      default:                        rs2_is_signed = 1'b0;
    endcase
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_func3;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [XLEN-1:0]   r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_is_div;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_part;
  logic [XLEN:0]     w_div_diff;
  logic              w_div_ge;
  logic              w_neg;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_remv;
  logic [XLEN-1:0]   w_fix_res;
  logic              w_done_nxt;
  logic              w_res_we;

  assign w_accept  = (r_state == S_IDLE) & bus.start & ~bus.flush & ~rst;
  assign w_is_div  = bus.func3[2];
  assign w_sign_a  = rs1_is_signed(bus.func3) & bus.rs1[XLEN-1];
  assign w_sign_b  = rs2_is_signed(bus.func3) & bus.rs2[XLEN-1];
  assign w_mag_a   = w_sign_a ? (ZERO - bus.rs1) : bus.rs1;
  assign w_mag_b   = w_sign_b ? (ZERO - bus.rs2) : bus.rs2;
  assign w_div0    = w_is_div & (bus.rs2 == ZERO);
  assign w_ovf     = w_is_div & ~bus.func3[0] & (bus.rs1 == MOST_NEG) & (bus.rs2 == ALL_ONES);
  assign w_special = w_div0 | w_ovf;

  // Divide-by-zero and signed overflow resolve without iterating.
  always_comb begin
    w_special_res = ZERO;
    if (w_div0) begin
      w_special_res = bus.func3[1] ? bus.rs1 : ALL_ONES;
    end else if (w_ovf) begin
      w_special_res = bus.func3[1] ? ZERO : MOST_NEG;
    end else begin
      w_special_res = ZERO;
    end
  end

  // Multiply keeps the multiplier in acc[XLEN-1:0] and shifts the product in from the top;
  // divide keeps the dividend/quotient in acc[XLEN-1:0] with the partial remainder in r_rem.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : {(XLEN+1){1'b0}});
  assign w_div_part = {r_rem, r_acc[XLEN-1]};
  assign w_div_diff = w_div_part - {1'b0, r_op};
  assign w_div_ge   = ~w_div_diff[XLEN];

  assign w_neg  = r_sign_a ^ r_sign_b;
  assign w_prod = w_neg ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;
  assign w_quot = w_neg ? (ZERO - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_remv = r_sign_a ? (ZERO - r_rem) : r_rem;

  // Final result selection from the sign-corrected product, quotient or remainder.
  always_comb begin
    w_fix_res = ZERO;
    case (r_func3)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quot;
      3'b110, 3'b111:         w_fix_res = w_remv;
      default:                w_fix_res = ZERO;
    endcase
  end

  // Next-state and commit control; flush wins over everything, including a new start.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_res_we    = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_special) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
              w_res_we    = 1'b1;
            end else begin
              w_state_nxt = S_CALC;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_CALC: begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_FIX;
          end else begin
            w_state_nxt = S_CALC;
          end
        end
        S_FIX: begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_res_we    = 1'b1;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, per-cycle iteration and result/done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_func3  <= 3'b000;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_op     <= ZERO;
      r_acc    <= {(2*XLEN){1'b0}};
      r_rem    <= ZERO;
      r_done   <= 1'b0;
      r_result <= ZERO;
    end else begin
      r_done <= w_done_nxt;
      if (w_res_we) begin
        r_result <= (r_state == S_FIX) ? w_fix_res : w_special_res;
      end
      if (bus.flush) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_accept) begin
        r_cnt    <= {CNT_W{1'b0}};
        r_func3  <= bus.func3;
        r_sign_a <= w_sign_a;
        r_sign_b <= w_sign_b;
        r_op     <= w_is_div ? w_mag_b : w_mag_a;
        r_acc    <= {ZERO, (w_is_div ? w_mag_a : w_mag_b)};
        r_rem    <= ZERO;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_func3[2]) begin
          r_rem <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_part[XLEN-1:0];
          r_acc <= {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_div_ge};
        end else begin
          r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
        end
      end
    end
  end

  assign bus.busy   = (r_state == S_CALC) | (r_state == S_FIX);
  assign bus.stall  = w_accept | bus.busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized + directed bench for muldiv_sequencer, checked every cycle against a
// cycle-count/arithmetic reference model of the unit.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus();
  muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural RV32M results.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (f)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        ps = sa / sb; return ps[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        ps = sa % sb; return ps[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Reference model: one op in flight, described by accept cycle and done cycle.
  bit          m_pending = 1'b0;
  bit          m_long = 1'b0;
  int          m_accept = 0;
  int          m_done_cyc = 0;
  logic [31:0] m_val = 32'd0;
  logic [31:0] m_result = 32'd0;
  bit          e_idle, e_busy, e_done, e_stall;

  always @(negedge clk) begin
    e_idle  = !m_pending;
    e_done  = m_pending && (cyc == m_done_cyc);
    e_busy  = m_pending && m_long && (cyc > m_accept) && (cyc < m_done_cyc);
    e_stall = (e_idle && bus.start && !bus.flush && !rst) || e_busy;
    if (chk_en) begin
      check("done", bus.done, e_done);
      check("busy", bus.busy, e_busy);
      check("stall", bus.stall, e_stall);
      check("result", bus.result, m_result);
    end
    if (rst) begin
      m_pending = 1'b0;
      m_result  = 32'd0;
    end else if (bus.flush) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (m_long && cyc == m_done_cyc - 1) m_result = m_val;
      if (cyc == m_done_cyc) m_pending = 1'b0;
    end else if (bus.start) begin
      m_pending  = 1'b1;
      m_accept   = cyc;
      m_long     = !ref_special(bus.func3, bus.rs1, bus.rs2);
      m_done_cyc = cyc + (m_long ? 34 : 1);
      m_val      = ref_result(bus.func3, bus.rs1, bus.rs2);
      if (!m_long) m_result = m_val;
    end
  end

  // Issue one op with a single-cycle start, scramble operands afterwards, wait for done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int t0;
    bit seen;
    bus.start = 1'b1; bus.func3 = f; bus.rs1 = a; bus.rs2 = b;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    bus.func3 = 3'($urandom_range(0, 7));
    bus.rs1 = 32'($urandom);
    bus.rs2 = 32'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        check({name, "_latency"}, 32'(cyc - t0), 32'(lat));
        check({name, "_value"}, bus.result, exp);
      end else begin
        tick();
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_done(input string name, output int t);
    bit seen;
    seen = 1'b0;
    t = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        t = cyc;
      end else begin
        tick();
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, n;
    logic [2:0] f;
    logic [31:0] a, b;

    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.func3 = 3'd0; bus.rs1 = 32'd0; bus.rs2 = 32'd0;

    check("model_mul", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model_mulh", ref_result(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("model_mulhu", ref_result(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("model_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    check("model_div", ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem", ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_result", bus.result, 32'd0);
    check("reset_done", bus.done, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    tick();

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, "remu");
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    // Flush in CALC cycle 10, then a fresh op.
    bus.start = 1'b1; bus.func3 = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd5;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    while (cyc < t0 + 10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 1'b0);
    check("flush_done", bus.done, 1'b0);
    run_op(3'd5, 32'd1000, 32'd9, 32'd111, 34, "after_flush");

    // Reset in the middle of CALC clears result.
    bus.start = 1'b1; bus.func3 = 3'd3; bus.rs1 = 32'd12; bus.rs2 = 32'd12;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    while (cyc < t0 + 12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_result", bus.result, 32'd0);
    run_op(3'd0, 32'd12, 32'd12, 32'd144, 34, "after_rst");

    // Back-to-back with start held high through DONE.
    bus.start = 1'b1; bus.func3 = 3'd0; bus.rs1 = 32'd6; bus.rs2 = 32'd7;
    t0 = cyc;
    tick();
    bus.func3 = 3'd5; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
    wait_done("b2b_first", t1);
    check("b2b_first_latency", 32'(t1 - t0), 32'd34);
    check("b2b_first_value", bus.result, 32'd42);
    tick();
    tick();
    bus.start = 1'b0;
    wait_done("b2b_second", t2);
    check("b2b_gap", 32'(t2 - t1), 32'd35);
    check("b2b_second_value", bus.result, 32'd14);
    tick();

    // Randomized ops with occasional flushes at arbitrary points.
    for (int i = 0; i < 80; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rand_operand();
      b = rand_operand();
      if ($urandom_range(0, 9) == 0) begin
        bus.start = 1'b1; bus.func3 = f; bus.rs1 = a; bus.rs2 = b;
        tick();
        bus.start = 1'b0;
        n = $urandom_range(0, 40);
        repeat (n) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
      end else begin
        run_op(f, a, b, ref_result(f, a, b), ref_special(f, a, b) ? 1 : 34, "rand");
      end
      n = $urandom_range(0, 2);
      repeat (n) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
